// File: rtl/period_meter.sv
// Period meter for a slow, asynchronous square wave: synchronizes sig_in, times
// the gap between edges in clk cycles, and reports half-period, period, lock and stall.
module period_meter #(
   parameter int W        = 32,
   parameter int TIMEOUT  = 1000000,
   parameter int LOCK_CNT = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         sig_in,
   output logic         rise_tick,
   output logic         fall_tick,
   output logic [W-1:0] half_period,
   output logic [W-1:0] period,
   output logic         meas_valid,
   output logic         locked,
   output logic         stalled
);

   // state  | meaning
   // SEARCH | no usable edge history; first edge tick arms the meter
   // ARMED  | one edge seen; next edge tick yields the first measurement
   // TRACK  | measuring every edge; lock once LOCK_CNT equal half-periods in a row
   typedef enum logic [1:0] {SEARCH, ARMED, TRACK} state_t;

   localparam int              MW      = $clog2(LOCK_CNT + 1);
   localparam logic [W-1:0]    CNT_MAX = '1;
   localparam logic [W-1:0]    TO_VAL  = W'(TIMEOUT);
   localparam logic [MW-1:0]   MC_MAX  = MW'(LOCK_CNT);

   state_t          state, state_next;
   logic            s1, s2, s3;
   logic [W-1:0]    cnt;
   logic [W-1:0]    high_time, low_time;
   logic            have_high, have_low;
   logic [MW-1:0]   mc;
   logic            tick, timeout;
   logic [W:0]      sum;

   assign tick    = rise_tick | fall_tick;
   // An edge tick landing on the timeout cycle wins: it is a valid measurement.
   assign timeout = (state != SEARCH) && (cnt == TO_VAL) && !tick;
   assign sum     = {1'b0, high_time} + {1'b0, low_time};
   assign locked  = (state == TRACK) && (mc == MC_MAX);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1        <= 1'b0;
         s2        <= 1'b0;
         s3        <= 1'b0;
         rise_tick <= 1'b0;
         fall_tick <= 1'b0;
      end else begin
         s1        <= sig_in;
         s2        <= s1;
         s3        <= s2;
         rise_tick <= s2 & ~s3;
         fall_tick <= ~s2 & s3;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (tick)
         cnt <= W'(1);
      else if (cnt != CNT_MAX)
         cnt <= cnt + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= SEARCH;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         SEARCH: if (tick) state_next = ARMED;
         ARMED: begin
            if (tick)
               state_next = TRACK;
            else if (timeout)
               state_next = SEARCH;
         end
         TRACK: if (timeout) state_next = SEARCH;
         default: state_next = SEARCH;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         half_period <= '0;
         period      <= '0;
         high_time   <= '0;
         low_time    <= '0;
         have_high   <= 1'b0;
         have_low    <= 1'b0;
         mc          <= '0;
         meas_valid  <= 1'b0;
         stalled     <= 1'b0;
      end else begin
         meas_valid <= 1'b0;
         // Period follows the measurement by one cycle, once both halves are known.
         if (meas_valid && have_high && have_low)
            period <= sum[W] ? CNT_MAX : sum[W-1:0];
         if (state == SEARCH) begin
            if (tick)
               stalled <= 1'b0;
         end else if (tick) begin
            half_period <= cnt;
            meas_valid  <= 1'b1;
            if (rise_tick) begin
               low_time <= cnt;
               have_low <= 1'b1;
            end else begin
               high_time <= cnt;
               have_high <= 1'b1;
            end
            if (state == ARMED || cnt != half_period)
               mc <= MW'(1);
            else if (mc != MC_MAX)
               mc <= mc + 1'b1;
         end else if (timeout) begin
            stalled   <= 1'b1;
            mc        <= '0;
            high_time <= '0;
            low_time  <= '0;
            have_high <= 1'b0;
            have_low  <= 1'b0;
            period    <= '0;
         end
      end
   end

endmodule

// File: tb/tb_period_meter.sv
// Directed bench for period_meter: edge latency, lock/relock, timeout boundary,
// stall recovery, asymmetric duty and reset mid-period.
module tb_period_meter;
   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         sig_in = 1'b0;
   logic         rise_tick, fall_tick, meas_valid, locked, stalled;
   logic [W-1:0] half_period, period;

   int n_chk = 0;
   int n_err = 0;
   int meas_n = 0;
   int rise_n = 0;
   int fall_n = 0;
   int m0;
   int waited;

   period_meter #(.W(W), .TIMEOUT(1000), .LOCK_CNT(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .sig_in      (sig_in),
      .rise_tick   (rise_tick),
      .fall_tick   (fall_tick),
      .half_period (half_period),
      .period      (period),
      .meas_valid  (meas_valid),
      .locked      (locked),
      .stalled     (stalled)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (meas_valid) meas_n++;
      if (rise_tick) rise_n++;
      if (fall_tick) fall_n++;
   end

   task automatic check(input string tag, input longint got, input longint exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Toggle sig_in, then hold it for n cycles (next toggle lands n cycles later).
   task automatic half_cycle(input int n);
      sig_in = ~sig_in;
      wait_cyc(n);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_half"}, half_period, 0);
      check({tag, "_period"}, period, 0);
      check({tag, "_rise"}, rise_tick, 0);
      check({tag, "_fall"}, fall_tick, 0);
      check({tag, "_meas"}, meas_valid, 0);
      check({tag, "_locked"}, locked, 0);
      check({tag, "_stalled"}, stalled, 0);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      wait_cyc(3);
      check_zero("reset");
      rst = 1'b0;
      wait_cyc(5);

      // E1 rise: tick after the third sampling edge, one cycle wide
      sig_in = 1'b1;
      wait_cyc(2);
      check("rise_lat2", rise_tick, 0);
      wait_cyc(1);
      check("rise_lat3", rise_tick, 1);
      wait_cyc(1);
      check("rise_width", rise_tick, 0);
      check("rise_count", rise_n, 1);
      check("fall_none", fall_n, 0);
      check("meas_after_first", meas_n, 0);
      wait_cyc(96);

      // 50% duty, 100-cycle halves: lock after 5th edge
      half_cycle(100);
      check("e2_half", half_period, 100);
      check("e2_meas", meas_n, 1);
      check("e2_period", period, 0);
      check("e2_locked", locked, 0);
      half_cycle(100);
      check("e3_period", period, 200);
      check("e3_locked", locked, 0);
      half_cycle(100);
      check("e4_locked", locked, 0);
      half_cycle(101);
      check("e5_locked", locked, 1);
      check("e5_half", half_period, 100);
      check("e5_meas", meas_n, 4);
      check("e5_falls", fall_n, 2);

      // One 101 half-period breaks lock, four more 100s relock
      half_cycle(100);
      check("e6_half", half_period, 101);
      check("e6_locked", locked, 0);
      check("e6_period", period, 201);
      for (int k = 0; k < 3; k++) half_cycle(100);
      check("e9_locked", locked, 0);
      half_cycle(1000);
      check("e10_locked", locked, 1);

      // Edge exactly at TIMEOUT is measured, not a stall
      sig_in = ~sig_in;
      wait_cyc(4);
      check("e11_half", half_period, 1000);
      check("e11_stalled", stalled, 0);
      check("e11_locked", locked, 0);

      waited = 1;
      while (!stalled && waited < 3000) begin
         wait_cyc(1);
         waited++;
      end
      check("stall_time_ok", (waited >= 1000 && waited <= 1001), 1);
      check("stall_set", stalled, 1);
      check("stall_locked", locked, 0);
      check("stall_period", period, 0);
      check("stall_half_hold", half_period, 1000);

      // Next edge clears stall and only re-arms
      m0 = meas_n;
      sig_in = ~sig_in;
      wait_cyc(3);
      check("e12_stall_hold", stalled, 1);
      wait_cyc(1);
      check("e12_stall_clear", stalled, 0);
      wait_cyc(1);
      check("e12_no_meas", meas_n, m0);
      wait_cyc(95);

      // 30 high / 70 low
      half_cycle(30);
      check("e13_half", half_period, 100);
      check("e13_period", period, 0);
      check("e13_meas", meas_n, m0 + 1);
      half_cycle(70);
      check("e14_half", half_period, 30);
      check("e14_period", period, 130);
      half_cycle(30);
      check("e15_half", half_period, 70);
      check("e15_period", period, 100);
      check("e15_locked", locked, 0);
      half_cycle(70);
      check("e16_half", half_period, 30);
      check("e16_period", period, 100);
      half_cycle(20);
      check("e17_half", half_period, 70);
      check("e17_locked", locked, 0);

      // Reset mid-period with sig_in high
      rst = 1'b1;
      #1;
      check_zero("midrst");
      wait_cyc(2);
      rst = 1'b0;
      m0 = meas_n;
      wait_cyc(2);
      check("rel_rise_lat2", rise_tick, 0);
      wait_cyc(1);
      check("rel_rise_lat3", rise_tick, 1);
      wait_cyc(50);
      check("rel_no_meas", meas_n, m0);
      sig_in = 1'b0;
      wait_cyc(5);
      check("rel_meas", meas_n, m0 + 1);
      check("rel_half", half_period, 53);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
